// File: rtl/mdc_stream_pack_fifo.sv
// Packs PACK input words into one strobed output beat and buffers beats in a DEPTH-entry FIFO.
// Optional statistics counters are enabled with MDC_STREAM_PACK_FIFO_STATS_EN.
module mdc_stream_pack_fifo #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned PACK   = 1,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [DATA_W-1:0]          in_data_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic                       flush_i,
  output logic [DATA_W*PACK-1:0]     out_data_o,
  output logic [DATA_W*PACK/8-1:0]   out_strb_o,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [$clog2(DEPTH):0]     occupancy_o
`ifdef MDC_STREAM_PACK_FIFO_STATS_EN
  ,
  output logic [31:0]                stat_in_words_o,
  output logic [31:0]                stat_out_beats_o
`endif
);

  localparam int unsigned BeatW     = DATA_W * PACK;
  localparam int unsigned StrbW     = BeatW / 8;
  localparam int unsigned LaneStrbW = DATA_W / 8;
  localparam int unsigned LaneW     = (PACK > 1) ? $clog2(PACK) : 1;
  localparam int unsigned PtrW      = $clog2(DEPTH);
  localparam int unsigned CntW      = PtrW + 1;
  localparam logic [LaneW-1:0] LastLane = LaneW'(PACK - 1);
  localparam logic [CntW-1:0]  FullCnt  = CntW'(DEPTH);

  logic [BeatW-1:0] mem_q      [DEPTH];
  logic [StrbW-1:0] mem_strb_q [DEPTH];

  logic [CntW-1:0]  count_q;
  logic [PtrW-1:0]  rd_ptr_q, wr_ptr_q;
  logic [LaneW-1:0] lane_q;
  logic [BeatW-1:0] acc_q;
  logic [StrbW-1:0] strb_acc_q;
  logic             flush_pend_q, flush_pend_d;

  logic [BeatW-1:0] acc_word, push_data;
  logic [StrbW-1:0] strb_word, push_strb;
  logic full, accept, complete, flush_close, push, pop;

  // Accumulator with the incoming word merged into the current lane.
  always_comb begin
    acc_word  = acc_q;
    strb_word = strb_acc_q;
    for (int k = 0; k < PACK; k++) begin
      if (lane_q == LaneW'(k)) begin
        acc_word[k*DATA_W +: DATA_W]         = in_data_i;
        strb_word[k*LaneStrbW +: LaneStrbW]  = '1;
      end
    end
  end

  always_comb begin
    full        = (count_q == FullCnt);
    in_ready_o  = !flush_pend_q && ((lane_q != LastLane) || !full);
    accept      = in_valid_i && in_ready_o;
    complete    = accept && (lane_q == LastLane);
    // A flush only closes something if a partial beat exists after this cycle's accept.
    flush_close = flush_i && !flush_pend_q && !complete && ((lane_q != '0) || accept);
    push        = complete || ((flush_close || flush_pend_q) && !full);
    push_data   = accept ? acc_word : acc_q;
    push_strb   = accept ? strb_word : strb_acc_q;
    pop         = (count_q != '0) && out_ready_i;

    flush_pend_d = flush_pend_q;
    if (flush_close && full) begin
      flush_pend_d = 1'b1;
    end else if (flush_pend_q && !full) begin
      flush_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q      <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      lane_q       <= '0;
      acc_q        <= '0;
      strb_acc_q   <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      count_q      <= count_q + CntW'(push) - CntW'(pop);
      flush_pend_q <= flush_pend_d;
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (push) begin
        acc_q      <= '0;
        strb_acc_q <= '0;
        lane_q     <= '0;
      end else if (accept) begin
        acc_q      <= acc_word;
        strb_acc_q <= strb_word;
        lane_q     <= lane_q + LaneW'(1);
      end
    end
  end

  // Storage is not reset; outputs are gated by count so stale entries never show.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q]      <= push_data;
      mem_strb_q[wr_ptr_q] <= push_strb;
    end
  end

  always_comb begin
    out_valid_o = (count_q != '0);
    out_data_o  = out_valid_o ? mem_q[rd_ptr_q] : '0;
    out_strb_o  = out_valid_o ? mem_strb_q[rd_ptr_q] : '0;
    occupancy_o = count_q;
  end

`ifdef MDC_STREAM_PACK_FIFO_STATS_EN
  logic [31:0] stat_in_q, stat_out_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stat_in_q  <= '0;
      stat_out_q <= '0;
    end else begin
      if (accept) stat_in_q  <= stat_in_q + 32'd1;
      if (pop)    stat_out_q <= stat_out_q + 32'd1;
    end
  end

  assign stat_in_words_o  = stat_in_q;
  assign stat_out_beats_o = stat_out_q;
`endif

endmodule

// File: tb/tb_mdc_stream_pack_fifo.sv
// Bench for mdc_stream_pack_fifo: directed scenarios on three configurations plus a random
// stream on PACK=4 checked against a word-queue reference model.
module tb_mdc_stream_pack_fifo;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // A: PACK=1 DEPTH=4
  logic [31:0] a_in_data;  logic a_in_valid, a_in_ready, a_flush, a_out_valid, a_out_ready;
  logic [31:0] a_out_data; logic [3:0] a_out_strb; logic [2:0] a_occ;
  // B: PACK=2 DEPTH=2
  logic [31:0] b_in_data;  logic b_in_valid, b_in_ready, b_flush, b_out_valid, b_out_ready;
  logic [63:0] b_out_data; logic [7:0] b_out_strb; logic [1:0] b_occ;
  // C: PACK=4 DEPTH=4
  logic [31:0] c_in_data;  logic c_in_valid, c_in_ready, c_flush, c_out_valid, c_out_ready;
  logic [127:0] c_out_data; logic [15:0] c_out_strb; logic [2:0] c_occ;
`ifdef MDC_STREAM_PACK_FIFO_STATS_EN
  logic [31:0] a_si, a_so, b_si, b_so, c_si, c_so;
`endif

  mdc_stream_pack_fifo #(.DATA_W(32), .PACK(1), .DEPTH(4)) u_a (
    .clk_i(clk), .rst_i(rst), .in_data_i(a_in_data), .in_valid_i(a_in_valid),
    .in_ready_o(a_in_ready), .flush_i(a_flush), .out_data_o(a_out_data),
    .out_strb_o(a_out_strb), .out_valid_o(a_out_valid), .out_ready_i(a_out_ready),
    .occupancy_o(a_occ)
`ifdef MDC_STREAM_PACK_FIFO_STATS_EN
    , .stat_in_words_o(a_si), .stat_out_beats_o(a_so)
`endif
  );

  mdc_stream_pack_fifo #(.DATA_W(32), .PACK(2), .DEPTH(2)) u_b (
    .clk_i(clk), .rst_i(rst), .in_data_i(b_in_data), .in_valid_i(b_in_valid),
    .in_ready_o(b_in_ready), .flush_i(b_flush), .out_data_o(b_out_data),
    .out_strb_o(b_out_strb), .out_valid_o(b_out_valid), .out_ready_i(b_out_ready),
    .occupancy_o(b_occ)
`ifdef MDC_STREAM_PACK_FIFO_STATS_EN
    , .stat_in_words_o(b_si), .stat_out_beats_o(b_so)
`endif
  );

  mdc_stream_pack_fifo #(.DATA_W(32), .PACK(4), .DEPTH(4)) u_c (
    .clk_i(clk), .rst_i(rst), .in_data_i(c_in_data), .in_valid_i(c_in_valid),
    .in_ready_o(c_in_ready), .flush_i(c_flush), .out_data_o(c_out_data),
    .out_strb_o(c_out_strb), .out_valid_o(c_out_valid), .out_ready_i(c_out_ready),
    .occupancy_o(c_occ)
`ifdef MDC_STREAM_PACK_FIFO_STATS_EN
    , .stat_in_words_o(c_si), .stat_out_beats_o(c_so)
`endif
  );

  task automatic do_reset();
    rst = 1'b1;
    a_in_valid = 0; a_flush = 0; a_out_ready = 0; a_in_data = '0;
    b_in_valid = 0; b_flush = 0; b_out_ready = 0; b_in_data = '0;
    c_in_valid = 0; c_flush = 0; c_out_ready = 0; c_in_data = '0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Bounded push helpers; an expired wait counts as a failed comparison.
  task automatic push_a(input logic [31:0] w);
    int t = 0;
    a_in_data = w; a_in_valid = 1'b1;
    @(negedge clk);
    while (!a_in_ready && t < 50) begin @(negedge clk); t++; end
    if (!a_in_ready) begin n_checks++; $display("FAIL push_a timeout word %h", w); end
    @(posedge clk); #1;
    a_in_valid = 1'b0;
  endtask

  task automatic push_b(input logic [31:0] w);
    int t = 0;
    b_in_data = w; b_in_valid = 1'b1;
    @(negedge clk);
    while (!b_in_ready && t < 50) begin @(negedge clk); t++; end
    if (!b_in_ready) begin n_checks++; $display("FAIL push_b timeout word %h", w); end
    @(posedge clk); #1;
    b_in_valid = 1'b0;
  endtask

  task automatic push_c(input logic [31:0] w);
    int t = 0;
    c_in_data = w; c_in_valid = 1'b1;
    @(negedge clk);
    while (!c_in_ready && t < 50) begin @(negedge clk); t++; end
    if (!c_in_ready) begin n_checks++; $display("FAIL push_c timeout word %h", w); end
    @(posedge clk); #1;
    c_in_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (a_out_valid !== 1'b0) $display("FAIL rst_valid got %b want 0", a_out_valid);
    else n_pass++;
    n_checks++; if (a_out_data !== 32'h0) $display("FAIL rst_data got %h want 0", a_out_data);
    else n_pass++;
    n_checks++; if (a_out_strb !== 4'h0) $display("FAIL rst_strb got %h want 0", a_out_strb);
    else n_pass++;
    n_checks++; if (a_occ !== 3'd0) $display("FAIL rst_occ got %0d want 0", a_occ);
    else n_pass++;
    n_checks++; if (a_in_ready !== 1'b1) $display("FAIL rst_ready got %b want 1", a_in_ready);
    else n_pass++;
    n_checks++; if (c_in_ready !== 1'b1) $display("FAIL rst_ready_c got %b want 1", c_in_ready);
    else n_pass++;
  endtask

  task automatic test_plain_fifo();
    do_reset();
    for (int i = 1; i <= 4; i++) push_a(32'h11 * i);
    n_checks++; if (a_occ !== 3'd4) $display("FAIL fifo_occ got %0d want 4", a_occ);
    else n_pass++;
    n_checks++; if (a_in_ready !== 1'b0) $display("FAIL fifo_full_ready got %b want 0", a_in_ready);
    else n_pass++;
    a_out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      n_checks++;
      if (a_out_valid !== 1'b1 || a_out_data !== 32'h11 * i)
        $display("FAIL fifo_pop%0d got %b/%h want 1/%h", i, a_out_valid, a_out_data, 32'h11 * i);
      else n_pass++;
      @(posedge clk); #1;
      if (i == 1) begin
        n_checks++; if (a_in_ready !== 1'b1) $display("FAIL fifo_ready_after_pop got %b want 1",
                                                      a_in_ready);
        else n_pass++;
      end
    end
    a_out_ready = 1'b0;
    n_checks++; if (a_out_valid !== 1'b0) $display("FAIL fifo_empty got %b want 0", a_out_valid);
    else n_pass++;
  endtask

  task automatic test_pack2();
    do_reset();
    push_b(32'hA);
    push_b(32'hB);
    n_checks++;
    if (b_out_valid !== 1'b1 || b_out_data !== 64'h0000000B_0000000A)
      $display("FAIL pack2_data got %b/%h want 1/0000000b0000000a", b_out_valid, b_out_data);
    else n_pass++;
    n_checks++; if (b_out_strb !== 8'hFF) $display("FAIL pack2_strb got %h want ff", b_out_strb);
    else n_pass++;
    b_out_ready = 1'b1; @(posedge clk); #1; b_out_ready = 1'b0;
    n_checks++; if (b_out_valid !== 1'b0) $display("FAIL pack2_drain got %b want 0", b_out_valid);
    else n_pass++;
  endtask

  task automatic test_flush_partial();
    do_reset();
    push_c(32'd1); push_c(32'd2); push_c(32'd3);
    c_flush = 1'b1; @(posedge clk); #1; c_flush = 1'b0;
    n_checks++;
    if (c_out_data !== 128'h00000000_00000003_00000002_00000001)
      $display("FAIL flush_data got %h want 00000000000000030000000200000001", c_out_data);
    else n_pass++;
    n_checks++; if (c_out_strb !== 16'h0FFF) $display("FAIL flush_strb got %h want 0fff", c_out_strb);
    else n_pass++;
    for (int i = 4; i <= 7; i++) push_c(i);
    c_out_ready = 1'b1; @(posedge clk); #1;
    n_checks++;
    if (c_out_data !== 128'h00000007_00000006_00000005_00000004 || c_out_strb !== 16'hFFFF)
      $display("FAIL flush_next_beat got %h/%h want 00000007000000060000000500000004/ffff",
               c_out_data, c_out_strb);
    else n_pass++;
    @(posedge clk); #1; c_out_ready = 1'b0;
    // Flush with nothing open is a no-op.
    c_flush = 1'b1; @(posedge clk); #1; c_flush = 1'b0;
    n_checks++; if (c_occ !== 3'd0) $display("FAIL flush_noop got %0d want 0", c_occ);
    else n_pass++;
    // Flush alongside the completing accept yields one full beat only.
    push_c(32'd8); push_c(32'd9); push_c(32'd10);
    c_flush = 1'b1; push_c(32'd11); c_flush = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (c_occ !== 3'd1 || c_out_strb !== 16'hFFFF)
      $display("FAIL flush_complete got occ %0d strb %h want 1/ffff", c_occ, c_out_strb);
    else n_pass++;
    // Flush alongside a non-completing accept includes that word.
    c_flush = 1'b1; push_c(32'd12); c_flush = 1'b0;
    c_out_ready = 1'b1; @(posedge clk); #1;
    n_checks++;
    if (c_out_data !== 128'h0000000C || c_out_strb !== 16'h000F)
      $display("FAIL flush_with_accept got %h/%h want 0000000c/000f", c_out_data, c_out_strb);
    else n_pass++;
    @(posedge clk); #1; c_out_ready = 1'b0;
    n_checks++; if (c_out_valid !== 1'b0) $display("FAIL flush_drain got %b want 0", c_out_valid);
    else n_pass++;
  endtask

  task automatic test_flush_full();
    do_reset();
    for (int i = 1; i <= 5; i++) push_b(i);
    b_flush = 1'b1; @(posedge clk); #1; b_flush = 1'b0;
    n_checks++;
    if (b_in_ready !== 1'b0 || b_occ !== 2'd2)
      $display("FAIL pend_hold got ready %b occ %0d want 0/2", b_in_ready, b_occ);
    else n_pass++;
    b_out_ready = 1'b1; @(posedge clk); #1; b_out_ready = 1'b0;
    n_checks++;
    if (b_in_ready !== 1'b0 || b_occ !== 2'd1)
      $display("FAIL pend_after_pop got ready %b occ %0d want 0/1", b_in_ready, b_occ);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (b_in_ready !== 1'b1 || b_occ !== 2'd2)
      $display("FAIL pend_push got ready %b occ %0d want 1/2", b_in_ready, b_occ);
    else n_pass++;
    b_out_ready = 1'b1;
    n_checks++;
    if (b_out_data !== 64'h00000004_00000003)
      $display("FAIL pend_beat1 got %h want 0000000400000003", b_out_data);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (b_out_data !== 64'h00000000_00000005 || b_out_strb !== 8'h0F)
      $display("FAIL pend_beat2 got %h/%h want 0000000000000005/0f", b_out_data, b_out_strb);
    else n_pass++;
    @(posedge clk); #1; b_out_ready = 1'b0;
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int i = 1; i <= 4; i++) push_b(i);
    push_b(32'd7);
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    n_checks++;
    if (b_out_valid !== 1'b0 || b_occ !== 2'd0 || b_in_ready !== 1'b1)
      $display("FAIL midrst got valid %b occ %0d ready %b want 0/0/1", b_out_valid, b_occ,
               b_in_ready);
    else n_pass++;
    push_b(32'h5); push_b(32'h6);
    n_checks++;
    if (b_out_data !== 64'h00000006_00000005 || b_out_strb !== 8'hFF || b_occ !== 2'd1)
      $display("FAIL midrst_after got %h/%h occ %0d want 0000000600000005/ff/1", b_out_data,
               b_out_strb, b_occ);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0]  cur[$];
    logic [127:0] exp_data[$];
    logic [15:0]  exp_strb[$];
    logic [127:0] bd;
    logic [15:0]  bs;
    logic acc, pop, done;
    int n = 800;
    do_reset();
    for (int i = 0; i < n; i++) begin
      if (i < n - 30) begin
        c_in_valid  = ($urandom_range(0, 3) != 0);
        c_in_data   = $urandom;
        c_flush     = ($urandom_range(0, 9) == 0);
        c_out_ready = ($urandom_range(0, 2) != 0);
      end else begin
        c_in_valid  = 1'b0;
        c_flush     = (i == n - 30);
        c_out_ready = 1'b1;
      end
      @(negedge clk);
      acc = c_in_valid && c_in_ready;
      pop = c_out_valid && c_out_ready;
      if (pop) begin
        n_checks++;
        if (exp_data.size() == 0) begin
          $display("FAIL rand_pop unexpected beat %h", c_out_data);
        end else begin
          if (c_out_data !== exp_data[0] || c_out_strb !== exp_strb[0])
            $display("FAIL rand_beat got %h/%h want %h/%h", c_out_data, c_out_strb, exp_data[0],
                     exp_strb[0]);
          else n_pass++;
          void'(exp_data.pop_front());
          void'(exp_strb.pop_front());
        end
      end
      done = 1'b0;
      if (acc) cur.push_back(c_in_data);
      if (cur.size() == 4 || (c_flush && cur.size() > 0)) begin
        // A completing beat makes the same-cycle flush a no-op.
        done = 1'b1;
        bd = '0; bs = '0;
        for (int k = 0; k < cur.size(); k++) begin
          bd[k*32 +: 32] = cur[k];
          bs[k*4 +: 4]   = 4'hF;
        end
        exp_data.push_back(bd);
        exp_strb.push_back(bs);
      end
      if (done) cur.delete();
      @(posedge clk); #1;
    end
    c_flush = 1'b0; c_out_ready = 1'b0;
    n_checks++;
    if (exp_data.size() != 0 || c_out_valid !== 1'b0)
      $display("FAIL rand_drain got %0d beats left valid %b want 0/0", exp_data.size(),
               c_out_valid);
    else n_pass++;
  endtask

`ifdef MDC_STREAM_PACK_FIFO_STATS_EN
  task automatic test_stats();
    do_reset();
    b_out_ready = 1'b1;
    for (int i = 1; i <= 7; i++) push_b(i);
    repeat (4) @(posedge clk);
    #1; b_out_ready = 1'b0;
    n_checks++;
    if (b_si !== 32'd7 || b_so !== 32'd3)
      $display("FAIL stats got in %0d out %0d want 7/3", b_si, b_so);
    else n_pass++;
    do_reset();
    n_checks++;
    if (b_si !== 32'd0 || b_so !== 32'd0)
      $display("FAIL stats_rst got in %0d out %0d want 0/0", b_si, b_so);
    else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_plain_fifo();
    test_pack2();
    test_flush_partial();
    test_flush_full();
    test_mid_reset();
    test_random();
`ifdef MDC_STREAM_PACK_FIFO_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mdc_stream_pack_fifo.md
Name: mdc_stream_pack_fifo

Overview:
Parametrised successor to the flat MDC-to-HWPE stream bridges. It sits between a flat valid/ready MDC actor output and the HWPE streamer sink, and adds two things the bridges lack: buffering in a DEPTH-entry FIFO, and width upsizing by packing PACK input words into one output beat with byte strobes. A flush input emits a partial beat at end-of-frame.

Parameters:
- DATA_W, 32, input word width in bits; multiple of 8.
- PACK, 1, input words per output beat; ≥1.
- DEPTH, 4, FIFO entries of packed beats; power of 2, ≥2.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; one clock; synchronous, active-high.
- in_data_i  in  DATA_W  input word from the MDC actor.
- in_valid_i  in  1  input valid.
- in_ready_o  out  1  input ready.
- flush_i  in  1  single-cycle pulse; close the current partial beat.
- out_data_o  out  DATA_W*PACK  packed beat; lane k occupies bits [(k+1)*DATA_W-1 : k*DATA_W].
- out_strb_o  out  DATA_W*PACK/8  byte strobes for out_data_o.
- out_valid_o  out  1  output valid.
- out_ready_i  in  1  output ready.
- occupancy_o  out  $clog2(DEPTH)+1  number of FIFO entries in use.

Behaviour:
- Reset (rst_i=1 at a clock edge) clears everything:
  - count, rd_ptr, wr_ptr, lane_q, acc_q, strb_acc_q and flush_pend_q all go to 0.
  - Outputs after reset: out_valid_o=0, out_data_o=0, out_strb_o=0, occupancy_o=0, in_ready_o=1.
  - A reset mid-operation discards FIFO contents and any partial beat.
- Input handshake:
  - A word is accepted when in_valid_i && in_ready_o.
  - The word is written into lane lane_q of acc_q, and that lane's strobe bits are set.
  - lane_q increments on each accept and wraps to 0 after PACK-1.
- in_ready_o:
  - 0 while flush_pend_q=1.
  - Otherwise 1 when lane_q≠PACK-1.
  - Otherwise (lane_q=PACK-1) it equals !(count==DEPTH).
  - It never depends on out_ready_i; there is no full-cycle pass-through.
- Beat completion:
  - Accepting lane PACK-1 pushes {acc, word} into the FIFO with all strobes set.
  - In the same cycle the accumulator and strobes clear and lane_q returns to 0.
  - PACK=1 degenerates to a plain FIFO.
- Flush:
  - If flush_i=1 and (lane_q>0 or the same-cycle accept does not complete a beat), push the partial beat. It includes any word accepted that cycle; unfilled lanes are 0 and their strobes are 0.
  - If the flush closes nothing, it is a no-op. This covers lane_q=0 with no accept, and a same-cycle accept that completes a beat (the full beat is pushed normally).
  - If the FIFO is full at the flush, set flush_pend_q. The pending flush pushes in the first cycle with count<DEPTH, then clears; in_ready_o stays 0 until then.
  - flush_i while flush_pend_q=1 is ignored.
- FIFO:
  - Registered output: out_valid_o = (count≠0), out_data_o/out_strb_o = mem[rd_ptr]. Both are driven to 0 when the FIFO is empty.
  - Pop occurs when out_valid_o && out_ready_i.
  - Pointers wrap modulo DEPTH.
  - Push and pop in the same cycle leave count unchanged.
  - No empty bypass: minimum latency from the completing accept to out_valid_o is 1 cycle.
  - Output data and strobes are held stable while out_valid_o && !out_ready_i.
- occupancy_o = count, registered.
- Overflow and underflow are impossible by construction.

Optional Feature:
- Macro: MDC_STREAM_PACK_FIFO_STATS_EN.
- With the macro defined, two extra outputs are present:
  - stat_in_words_o (32 bits): counts accepted input words.
  - stat_out_beats_o (32 bits): counts popped beats.
  - Both wrap at 2^32 and reset to 0 on rst_i.
- Without the macro, these ports and their counters do not exist and behaviour is otherwise identical.

Test Plan:
1. PACK=1, DEPTH=4, out_ready_i=0; push 0x11, 0x22, 0x33, 0x44 → occupancy_o=4 and in_ready_o=0. Then set out_ready_i=1 → outputs 0x11, 0x22, 0x33, 0x44 on consecutive cycles, and in_ready_o=1 one cycle after the first pop.
2. PACK=2; push 0x0000000A then 0x0000000B → one cycle after the second accept, out_data_o=0x0000000B_0000000A and out_strb_o=0xFF.
3. PACK=4; push 1, 2, 3, then pulse flush_i with no accept → out_data_o=0x00000000_00000003_00000002_00000001, out_strb_o=0x0FFF. The next beat starts at lane 0.
4. PACK=2, DEPTH=2; fill the FIFO, push one word, pulse flush_i → in_ready_o stays 0. After one pop, the partial beat (strb 0x0F) is enqueued the next cycle and in_ready_o returns to 1.
5. PACK=2; two beats queued plus one lane filled, then rst_i=1 for one cycle → out_valid_o=0 and occupancy_o=0. The next pushes 0x5, 0x6 yield 0x00000006_00000005.
6. With the stats macro defined: 7 words pushed and 3 beats popped (PACK=2) → stat_in_words_o=7, stat_out_beats_o=3; both read 0 after reset.
